// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_cmd_pkg : shared types and constants for the UART command decoder  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
`ifdef UART_CMD_CHECKSUM_EN
    ST_CSUM  = 3'd4,
`endif
    ST_ISSUE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_BAD_CMD = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_cmd_decoder_if : byte stream in, command and error out            |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface uart_cmd_decoder_if #(
  parameter int DATA_BYTES = 4
);
  logic                    com_valid;
  logic [7:0]              com_rdata;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [7:0]              cmd_addr;
  logic [8*DATA_BYTES-1:0] cmd_wdata;
  logic                    err_valid;
  logic [1:0]              err_code;

  modport master (
    output com_valid, com_rdata, cmd_ready,
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_valid, err_code
  );

  modport slave (
    input  com_valid, com_rdata, cmd_ready,
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_valid, err_code
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_cmd_timer : inter-byte timeout counter with clear/enable/expired  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic clear_i,
  input  wire logic en_i,
  output logic      expired_o
);
  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_cmd_decoder : frames SYNC/CMD/ADDR/DATA[/CSUM] into register cmds |
// | Checksum byte enabled by UART_CMD_CHECKSUM_EN.   Rev 1.0               |
// +------------------------------------------------------------------------+
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int         DATA_BYTES     = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input wire logic            clk,
  input wire logic            rstn,
  uart_cmd_decoder_if.slave   bus
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t ST_POST = ST_CSUM;
`else
  localparam state_t ST_POST = ST_ISSUE;
`endif

  state_t          state_q, state_d;
  logic            write_q, write_d;
  logic [7:0]      addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_valid_q, err_valid_d;
  err_code_t       err_code_q, err_code_d;
  logic            timed;
  logic            expired;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  assign timed = (state_q != ST_IDLE) && (state_q != ST_ISSUE);

  uart_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .clear_i   (bus.com_valid || (state_d != state_q) || !timed),
    .en_i      (timed),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    err_valid_d = 1'b0;
    err_code_d  = ERR_BAD_CMD;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    if (expired && !bus.com_valid) begin
      state_d     = ST_IDLE;
      err_valid_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.com_valid && bus.com_rdata == SYNC_BYTE) begin
          state_d = ST_CMD;
          wdata_d = '0;
          idx_d   = '0;
        end
        ST_CMD: if (bus.com_valid) begin
          if (bus.com_rdata == OP_WRITE || bus.com_rdata == OP_READ) begin
            state_d = ST_ADDR;
            write_d = (bus.com_rdata == OP_WRITE);
`ifdef UART_CMD_CHECKSUM_EN
            csum_d  = bus.com_rdata;
`endif
          end else begin
            state_d     = ST_IDLE;
            err_valid_d = 1'b1;
            err_code_d  = ERR_BAD_CMD;
          end
        end
        ST_ADDR: if (bus.com_valid) begin
          addr_d  = bus.com_rdata;
          idx_d   = '0;
          state_d = write_q ? ST_DATA : ST_POST;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ bus.com_rdata;
`endif
        end
        ST_DATA: if (bus.com_valid) begin
          wdata_d = (wdata_q << 8) | DW'(bus.com_rdata);
          idx_d   = idx_q + IW'(1);
`ifdef UART_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ bus.com_rdata;
`endif
          if (idx_q == IW'(DATA_BYTES - 1)) state_d = ST_POST;
        end
`ifdef UART_CMD_CHECKSUM_EN
        ST_CSUM: if (bus.com_valid) begin
          if (bus.com_rdata == csum_q) begin
            state_d = ST_ISSUE;
          end else begin
            state_d     = ST_IDLE;
            err_valid_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
`endif
        ST_ISSUE: begin
          if (bus.cmd_ready) state_d = ST_IDLE;
          if (bus.com_valid) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_OVERRUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_BAD_CMD;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.cmd_valid = (state_q == ST_ISSUE);
  assign bus.cmd_write = write_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_wdata = wdata_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_uart_cmd_decoder : directed bench; honours UART_CMD_CHECKSUM_EN     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_uart_cmd_decoder;
  localparam int TO = 16;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  uart_cmd_decoder_if #(.DATA_BYTES(4)) bus ();

  uart_cmd_decoder #(
    .DATA_BYTES     (4),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.com_valid = 1'b1;
    bus.com_rdata = b;
    tick();
    bus.com_valid = 1'b0;
    bus.com_rdata = 8'h00;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input logic wr, input logic [7:0] a,
                           input logic [31:0] d);
    check({tag, "_valid"}, 64'(bus.cmd_valid), 64'd1);
    check({tag, "_write"}, 64'(bus.cmd_write), 64'(wr));
    check({tag, "_addr"},  64'(bus.cmd_addr),  64'(a));
    check({tag, "_wdata"}, 64'(bus.cmd_wdata), 64'(d));
  endtask

  task automatic check_err(input string tag, input logic v, input logic [1:0] c);
    check({tag, "_errv"}, 64'(bus.err_valid), 64'(v));
    check({tag, "_errc"}, 64'(bus.err_code),  64'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rstn          = 1'b0;
    bus.com_valid = 1'b0;
    bus.com_rdata = 8'h00;
    bus.cmd_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_cmdv",  64'(bus.cmd_valid), 64'd0);
    check("rst_write", 64'(bus.cmd_write), 64'd0);
    check("rst_addr",  64'(bus.cmd_addr),  64'd0);
    check("rst_wdata", 64'(bus.cmd_wdata), 64'd0);
    check_err("rst", 1'b0, 2'd0);
    rstn = 1'b1;
    tick();

    // 1: write frame, command visible right after the last byte
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef UART_CMD_CHECKSUM_EN
    check("t1_pre_csum", 64'(bus.cmd_valid), 64'd0);
    send_byte(8'h33);
`endif
    check_cmd("t1", 1'b1, 8'h10, 32'hDEADBEEF);
    check_err("t1", 1'b0, 2'd0);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("t1_drop", 64'(bus.cmd_valid), 64'd0);
    tick();
    check("t1_once", 64'(bus.cmd_valid), 64'd0);

    // 2: read frame held under back-pressure
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h3E);
`endif
    for (int i = 0; i < 5; i++) begin
      check_cmd("t2_hold", 1'b0, 8'h3C, 32'h0);
      tick();
    end
    check_cmd("t2_last", 1'b0, 8'h3C, 32'h0);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("t2_drop", 64'(bus.cmd_valid), 64'd0);

    // 3: junk bytes silently dropped, bad opcode flagged, recovery
    send_byte(8'h00);
    check_err("t3_00", 1'b0, 2'd0);
    send_byte(8'hFF);
    check_err("t3_ff", 1'b0, 2'd0);
    send_byte(8'hA5);
    send_byte(8'h07);
    check_err("t3_bad", 1'b1, 2'd0);
    check("t3_nocmd", 64'(bus.cmd_valid), 64'd0);
    tick();
    check("t3_pulse", 64'(bus.err_valid), 64'd0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h77);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h75);
`endif
    check_cmd("t3_rec", 1'b0, 8'h77, 32'h0);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;

    // 4a: timeout after TO idle cycles mid-frame
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    repeat (TO - 1) tick();
    check_err("t4_before", 1'b0, 2'd0);
    tick();
    check_err("t4_to", 1'b1, 2'd2);
    check("t4_nocmd", 64'(bus.cmd_valid), 64'd0);
    tick();
    check_err("t4_clr", 1'b0, 2'd0);

    // 4b: byte on the expiry cycle is accepted and the frame completes
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    repeat (TO - 1) tick();
    send_byte(8'hDE);
    check_err("t4_edge", 1'b0, 2'd0);
    send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h33);
`endif
    check_cmd("t4_edge", 1'b1, 8'h10, 32'hDEADBEEF);

    // 5: overrun while the previous command is still pending
    send_byte(8'h55);
    check_err("t5_ovr", 1'b1, 2'd3);
    check_cmd("t5_keep", 1'b1, 8'h10, 32'hDEADBEEF);
    tick();
    check_err("t5_clr", 1'b0, 2'd0);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("t5_drop", 64'(bus.cmd_valid), 64'd0);

`ifdef UART_CMD_CHECKSUM_EN
    // 6a: checksum mismatch
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C); send_byte(8'h00);
    check_err("t6_csum", 1'b1, 2'd1);
    check("t6_nocmd", 64'(bus.cmd_valid), 64'd0);
    tick();
`endif

    // 6b: reset in the middle of the data phase
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'hDE);
    rstn = 1'b0;
    tick();
    check("t6_rst_write", 64'(bus.cmd_write), 64'd0);
    check("t6_rst_addr",  64'(bus.cmd_addr),  64'd0);
    check("t6_rst_wdata", 64'(bus.cmd_wdata), 64'd0);
    check_err("t6_rst", 1'b0, 2'd0);
    rstn = 1'b1;
    send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h33);
    tick();
    check("t6_idle", 64'(bus.cmd_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
